// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states
// and the datapath mux select values.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REGB   = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_R_EXEC    = 4'd7,
      S_R_WB      = 4'd8,
      S_ADDI_EXEC = 4'd9,
      S_ADDI_WB   = 4'd10,
      S_BRANCH    = 4'd11,
      S_JUMP      = 4'd12,
      S_FAULT     = 4'd13
   } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the last
// allowed cycle; a zero MEM_TIMEOUT never times out.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic ready,
   output logic timeout
);

   localparam int W = (CNT_W < 1) ? 1 : CNT_W;
   localparam logic [W-1:0] LAST = W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   logic [W-1:0] cnt;

   // Held at zero outside memory states so every access starts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear || ready)
         cnt <= '0;
      else
         cnt <= cnt + W'(1);
   end

   assign timeout = (MEM_TIMEOUT != 0) && !clear && !ready && (cnt == LAST);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/
// writeback, waits on mem_ready with a timeout, and traps illegal opcodes.
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       instr_done,
   output logic       fault,
   output logic [3:0] state_dbg
);

   state_t state, next;
   logic   mem_state;
   logic   timeout;

   assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
   assign state_dbg = state;

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (!mem_state),
      .ready  (mem_ready),
      .timeout(timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_RESET;
      else
         state <= next;
   end

   always_comb begin
      next       = state;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REGB;
      alu_op     = ALU_ADD;
      pc_source  = PCSRC_ALU;
      fault      = 1'b0;

      case (state)
         S_RESET: next = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready)
               next = S_DECODE;
            else if (timeout)
               next = S_FAULT;
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            case (opcode)
               OP_LW, OP_SW:   next = S_MEM_ADDR;
               OP_RTYPE:       next = S_R_EXEC;
               OP_ADDI:        next = S_ADDI_EXEC;
               OP_BEQ, OP_BNE: next = S_BRANCH;
               OP_J:           next = S_JUMP;
               default:        next = S_FAULT;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            if (opcode == OP_LW)
               next = S_MEM_READ;
            else if (opcode == OP_SW)
               next = S_MEM_WRITE;
            else
               next = S_FAULT;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready)
               next = S_MEM_WB;
            else if (timeout)
               next = S_FAULT;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            next       = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready)
               next = S_FETCH;
            else if (timeout)
               next = S_FAULT;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
            next      = S_R_WB;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            next      = S_FETCH;
         end
         S_ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            next      = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            reg_write = 1'b1;
            next      = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_source = PCSRC_ALUOUT;
            pc_write  = (opcode == OP_BNE) ? !zero : zero;
            next      = S_FETCH;
         end
         S_JUMP: begin
            pc_source = PCSRC_JUMP;
            pc_write  = 1'b1;
            next      = S_FETCH;
         end
         S_FAULT: fault = 1'b1;
         default: next = S_FAULT;
      endcase
   end

   // A FETCH that is still waiting is not the end of an instruction.
   assign instr_done = (next == S_FETCH) && (state != S_RESET) && (state != S_FETCH);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with MEM_TIMEOUT=4; each step checks
// the state and the full control word against hand-derived values.
module tb_mips_multicycle_ctrl;
   import mips_pkg::*;

   logic       clk, rst, zero, mem_ready;
   logic [5:0] opcode;
   logic       pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg;
   logic       reg_dst, reg_write, alu_src_a, instr_done, fault;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state_dbg;
   logic [16:0] ctl_w;

   int n_checks = 0;
   int n_fail   = 0;

   mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
      .fault(fault), .state_dbg(state_dbg)
   );

   assign ctl_w = {pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst,
                   reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, fault};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no end of test, required end before 100000");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [16:0] c(input logic pw, irw, io, mr, mw, m2r, rd, rw, asa,
                                     input logic [1:0] asb, aop, ps,
                                     input logic dn, fl);
      return {pw, irw, io, mr, mw, m2r, rd, rw, asa, asb, aop, ps, dn, fl};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are set at a falling edge, checked 1 unit later, then one cycle elapses.
   task automatic step(input string tag, input state_t es, input logic [16:0] ec);
      #1;
      chk({tag, "_state"}, 32'(state_dbg), 32'(es));
      chk({tag, "_ctl"}, 32'(ctl_w), 32'(ec));
      @(negedge clk);
   endtask

   initial begin
      logic [16:0] zero_c, fetch_rdy, fetch_wait, decode_c, fault_c;
      zero_c     = '0;
      fetch_rdy  = c(1,1,0,1,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
      fetch_wait = c(0,0,0,1,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
      decode_c   = c(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
      fault_c    = c(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1);

      rst = 1'b1; zero = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
      @(negedge clk); @(negedge clk);
      step("in_reset", S_RESET, zero_c);

      // R-type with no wait states
      rst = 1'b0;
      step("rel", S_RESET, zero_c);
      step("r_fetch", S_FETCH, fetch_rdy);
      step("r_decode", S_DECODE, decode_c);
      step("r_exec", S_R_EXEC, c(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0));
      step("r_wb", S_R_WB, c(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0));

      // lw with three wait cycles in MEM_READ; ready on the last allowed cycle
      opcode = 6'b100011;
      step("lw_fetch", S_FETCH, fetch_rdy);
      step("lw_decode", S_DECODE, decode_c);
      step("lw_addr", S_MEM_ADDR, c(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         step("lw_wait", S_MEM_READ, c(0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
      mem_ready = 1'b1;
      step("lw_rd", S_MEM_READ, c(0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
      step("lw_wb", S_MEM_WB, c(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0));

      // beq taken, bne with zero=1 not taken, bne with zero=0 taken
      opcode = 6'b000100; zero = 1'b1;
      step("beq_fetch", S_FETCH, fetch_rdy);
      step("beq_decode", S_DECODE, decode_c);
      step("beq_br", S_BRANCH, c(1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0));
      opcode = 6'b000101;
      step("bne_fetch", S_FETCH, fetch_rdy);
      step("bne_decode", S_DECODE, decode_c);
      step("bne_br", S_BRANCH, c(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0));
      zero = 1'b0;
      step("bne0_fetch", S_FETCH, fetch_rdy);
      step("bne0_decode", S_DECODE, decode_c);
      step("bne0_br", S_BRANCH, c(1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0));

      // addi, sw, j with no wait states
      opcode = 6'b001000;
      step("addi_fetch", S_FETCH, fetch_rdy);
      step("addi_decode", S_DECODE, decode_c);
      step("addi_exec", S_ADDI_EXEC, c(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
      step("addi_wb", S_ADDI_WB, c(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0));
      opcode = 6'b101011;
      step("sw_fetch", S_FETCH, fetch_rdy);
      step("sw_decode", S_DECODE, decode_c);
      step("sw_addr", S_MEM_ADDR, c(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
      step("sw_wr", S_MEM_WRITE, c(0,0,1,0,1,0,0,0,0,2'b00,2'b00,2'b00,1,0));
      opcode = 6'b000010;
      step("j_fetch", S_FETCH, fetch_rdy);
      step("j_decode", S_DECODE, decode_c);
      step("j_jump", S_JUMP, c(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0));

      // FETCH timeout after 4 not-ready cycles
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         step("to_wait", S_FETCH, fetch_wait);
      mem_ready = 1'b1;
      step("to_fault", S_FAULT, fault_c);
      #2 rst = 1'b1;
      #1 chk("to_rst_state", 32'(state_dbg), 32'(S_RESET));
      chk("to_rst_fault", 32'(fault), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step("to_rel", S_RESET, zero_c);

      // ready on the 4th FETCH cycle wins over the timeout
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         step("edge_wait", S_FETCH, fetch_wait);
      mem_ready = 1'b1;
      opcode = 6'b111111;
      step("edge_fetch", S_FETCH, fetch_rdy);

      // illegal opcode traps and holds until reset
      step("ill_decode", S_DECODE, decode_c);
      for (int i = 0; i < 20; i++)
         step("ill_fault", S_FAULT, fault_c);
      #2 rst = 1'b1;
      #1 chk("ill_rst_ctl", 32'(ctl_w), 32'(zero_c));
      @(negedge clk);
      rst = 1'b0;
      step("ill_rel", S_RESET, zero_c);

      // reset asserted during a MEM_WRITE wait
      opcode = 6'b101011;
      step("sw2_fetch", S_FETCH, fetch_rdy);
      step("sw2_decode", S_DECODE, decode_c);
      step("sw2_addr", S_MEM_ADDR, c(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
      mem_ready = 1'b0;
      step("sw2_wait", S_MEM_WRITE, c(0,0,1,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0));
      #1 chk("sw2_held", 32'(mem_write), 32'd1);
      #2 rst = 1'b1;
      #1 chk("sw2_rst_mw", 32'(mem_write), 32'd0);
      chk("sw2_rst_state", 32'(state_dbg), 32'(S_RESET));
      @(negedge clk);
      rst = 1'b0;
      mem_ready = 1'b1;
      opcode = 6'b000010;
      step("sw2_rel", S_RESET, zero_c);
      step("sw2_fetch2", S_FETCH, fetch_rdy);
      step("sw2_decode2", S_DECODE, decode_c);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
